sd_sched: RTL and testbench

SD_SCHED -- requirements
Module: sd_sched

---
 rtl/sd_sched.sv | 176 +++++++++++++++++
 tb/tb_sd_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sched.sv
// Two-requester arbiter in front of a single SD solver: grants the solver round-robin,
// forwards the owner's 81-nibble puzzle, routes the result burst back and guards it with a watchdog.
module sd_sched #(
  parameter int TIMEOUT = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       in_valid0,
  input  logic       in_valid1,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       sd_in_valid,
  output logic [3:0] sd_in,
  input  logic       sd_out_valid,
  input  logic [3:0] sd_out,
  output logic       out_valid0,
  output logic [3:0] out0,
  output logic       out_valid1,
  output logic [3:0] out1,
  output logic       done0,
  output logic       done1,
  output logic       err0,
  output logic       err1
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FEED  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  localparam logic [6:0]  NIB_LAST = 7'd80;

  logic [2:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_served_q, last_served_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [15:0] wd_q, wd_d;
  logic        sd_in_valid_q, sd_in_valid_d;
  logic [3:0]  sd_in_q, sd_in_d;

  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  out_valid_q, out_valid_d;
  logic [3:0]  out_q [2];
  logic [3:0]  out_d [2];
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;

  logic        own_valid;
  logic [3:0]  own_in;
  logic        timed_out;
  logic        busy_d;
  logic        res_fwd;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    cnt_d         = cnt_q;
    wd_d          = wd_q;
    timed_out     = 1'b0;
    own_valid     = owner_q ? in_valid1 : in_valid0;
    own_in        = owner_q ? in1 : in0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = FEED;
          // on a tie the requester that was not served last time wins
          owner_d = (req0 && req1) ? ~last_served_q : req1;
        end
      end
      FEED: begin
        if (own_valid) begin
          if (cnt_q == NIB_LAST) begin
            cnt_d   = 7'd0;
            state_d = WAIT;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      WAIT: begin
        if (sd_out_valid) begin
          wd_d    = 16'd0;
          state_d = DRAIN;
        end else if (wd_q == WD_LAST) begin
          wd_d      = 16'd0;
          state_d   = DONE;
          timed_out = 1'b1;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      DRAIN: begin
        if (!sd_out_valid) state_d = DONE;
      end
      DONE: begin
        last_served_d = owner_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d        = (state_d == FEED) || (state_d == WAIT) || (state_d == DRAIN);
    sd_in_valid_d = (state_q == FEED) && own_valid;
    sd_in_d       = sd_in_valid_d ? own_in : 4'd0;
    res_fwd       = ((state_q == WAIT) || (state_q == DRAIN)) && sd_out_valid;
  end

  // per-requester grant, result routing and completion flags
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    always_comb begin
      gnt_d[gi]       = busy_d && (owner_d == gi[0]);
      out_valid_d[gi] = res_fwd && (owner_q == gi[0]);
      out_d[gi]       = out_valid_d[gi] ? sd_out : 4'd0;
      done_d[gi]      = (state_d == DONE) && (state_q != DONE) && (owner_q == gi[0]);
      err_d[gi]       = timed_out && (owner_q == gi[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        gnt_q[gi]       <= 1'b0;
        out_valid_q[gi] <= 1'b0;
        out_q[gi]       <= 4'd0;
        done_q[gi]      <= 1'b0;
        err_q[gi]       <= 1'b0;
      end else begin
        gnt_q[gi]       <= gnt_d[gi];
        out_valid_q[gi] <= out_valid_d[gi];
        out_q[gi]       <= out_d[gi];
        done_q[gi]      <= done_d[gi];
        err_q[gi]       <= err_d[gi];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
      cnt_q         <= 7'd0;
      wd_q          <= 16'd0;
      sd_in_valid_q <= 1'b0;
      sd_in_q       <= 4'd0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      cnt_q         <= cnt_d;
      wd_q          <= wd_d;
      sd_in_valid_q <= sd_in_valid_d;
      sd_in_q       <= sd_in_d;
    end
  end

  assign gnt0        = gnt_q[0];
  assign gnt1        = gnt_q[1];
  assign sd_in_valid = sd_in_valid_q;
  assign sd_in       = sd_in_q;
  assign out_valid0  = out_valid_q[0];
  assign out0        = out_q[0];
  assign out_valid1  = out_valid_q[1];
  assign out1        = out_q[1];
  assign done0       = done_q[0];
  assign done1       = done_q[1];
  assign err0        = err_q[0];
  assign err1        = err_q[1];

endmodule

// File: tb/tb_sd_sched.sv
// Directed bench for sd_sched: table of single jobs plus hand-written reset,
// round-robin and timeout sequences, with a negedge monitor collecting the streams.
module tb_sd_sched;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, in_valid0, in_valid1;
  logic [3:0] in0, in1;
  logic       gnt0, gnt1, sd_in_valid;
  logic [3:0] sd_in;
  logic       sd_out_valid;
  logic [3:0] sd_out;
  logic       out_valid0, out_valid1;
  logic [3:0] out0, out1;
  logic       done0, done1, err0, err1;

  sd_sched #(.TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in0(in0), .in1(in1),
    .gnt0(gnt0), .gnt1(gnt1),
    .sd_in_valid(sd_in_valid), .sd_in(sd_in),
    .sd_out_valid(sd_out_valid), .sd_out(sd_out),
    .out_valid0(out_valid0), .out0(out0),
    .out_valid1(out_valid1), .out1(out1),
    .done0(done0), .done1(done1),
    .err0(err0), .err1(err1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // monitor state
  logic [3:0] sdin_q[$];
  int         sdin_c[$];
  logic [3:0] out_dat[$];
  int         out_c[$];
  int         n_outv[2];
  int         n_done[2];
  int         n_err[2];
  int         done_cyc;
  logic       gnt_at_done;
  int         overlap  = 0;
  int         zero_bad = 0;
  int         idle_run = 0;
  int         gaps[$];
  int         order[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (sd_in_valid) begin sdin_q.push_back(sd_in); sdin_c.push_back(cyc); end
      if (out_valid0) begin n_outv[0]++; out_dat.push_back(out0); out_c.push_back(cyc); end
      if (out_valid1) begin n_outv[1]++; out_dat.push_back(out1); out_c.push_back(cyc); end
      if (done0) begin n_done[0]++; done_cyc = cyc; gnt_at_done = gnt0; end
      if (done1) begin n_done[1]++; done_cyc = cyc; gnt_at_done = gnt1; end
      if (err0) n_err[0]++;
      if (err1) n_err[1]++;
      if (gnt0 && gnt1) overlap++;
      if ((!out_valid0 && out0 != 4'd0) || (!out_valid1 && out1 != 4'd0)) zero_bad++;
      if (!gnt0 && !gnt1) idle_run++;
      else begin
        if (idle_run > 0) begin gaps.push_back(idle_run); order.push_back(int'(gnt1)); end
        idle_run = 0;
      end
    end else begin
      idle_run = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int out_vec();
    return int'({gnt0, gnt1, sd_in_valid, sd_in, out_valid0, out0, out_valid1, out1,
                 done0, done1, err0, err1});
  endfunction

  task automatic drive_in(input int who, input logic v, input logic [3:0] d);
    if (who == 0) begin in_valid0 = v; in0 = d; end
    else begin in_valid1 = v; in1 = d; end
  endtask

  task automatic clear_mon();
    sdin_q.delete(); sdin_c.delete(); out_dat.delete(); out_c.delete();
    for (int s = 0; s < 2; s++) begin n_outv[s] = 0; n_done[s] = 0; n_err[s] = 0; end
    done_cyc = -1;
    gnt_at_done = 1'bx;
  endtask

  task automatic do_job(input int who, input bit gapped, input bit noise, input int burst,
                        input int exp_nout, input int exp_err, input bit keep, input string tag);
    logic [3:0] nib[81];
    int         drv[81];
    logic [3:0] val[15];
    int         odrv[15];
    int         i, e, lat_bad, dat_bad, oth;
    bit         got, ph;
    oth = 1 - who;
    for (int j = 0; j < 81; j++) nib[j] = (j % 5 == 0 && j < 75) ? 4'd0 : 4'((j % 9) + 1);
    for (int k = 0; k < 15; k++) val[k] = (burst == 1) ? 4'd10 : 4'((k % 9) + 1);
    clear_mon();
    if (who == 0) req0 = 1'b1; else req1 = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      tick();
      got = (who == 0) ? gnt0 : gnt1;
    end
    chk({tag, "_grant"}, int'(got), 1);
    if (!keep) begin if (who == 0) req0 = 1'b0; else req1 = 1'b0; end
    if (noise) drive_in(oth, 1'b1, 4'hF);
    i = 0; ph = 1'b0;
    while (i < 81) begin
      if (gapped && ph) drive_in(who, 1'b0, 4'd0);
      else begin drive_in(who, 1'b1, nib[i]); drv[i] = cyc; i++; end
      ph = ~ph;
      tick();
    end
    drive_in(who, 1'b0, 4'd0);
    drive_in(oth, 1'b0, 4'd0);
    e = drv[80] + 1;
    if (burst > 0) begin
      tick(); tick(); tick();
      for (int k = 0; k < burst; k++) begin
        sd_out_valid = 1'b1; sd_out = val[k]; odrv[k] = cyc;
        tick();
      end
      sd_out_valid = 1'b0; sd_out = 4'd0;
    end
    got = 1'b0;
    for (int t = 0; t < 150 && !got; t++) begin
      tick();
      got = (n_done[0] + n_done[1]) > 0;
    end
    chk({tag, "_done_seen"}, int'(got), 1);
    if (exp_err != 0) begin
      chk({tag, "_timeout_cycles"}, done_cyc - e, 100);
      sd_out_valid = 1'b1; sd_out = 4'd5;
      tick(); tick(); tick();
      sd_out_valid = 1'b0; sd_out = 4'd0;
    end
    tick(); tick();
    chk({tag, "_sdin_count"}, sdin_q.size(), 81);
    lat_bad = 0; dat_bad = 0;
    for (int j = 0; j < 81 && j < sdin_q.size(); j++) begin
      if (sdin_q[j] !== nib[j]) dat_bad++;
      if (sdin_c[j] - drv[j] != 1) lat_bad++;
    end
    chk({tag, "_sdin_data_err"}, dat_bad, 0);
    chk({tag, "_sdin_latency_err"}, lat_bad, 0);
    chk({tag, "_out_count_owner"}, n_outv[who], exp_nout);
    chk({tag, "_out_count_other"}, n_outv[oth], 0);
    lat_bad = 0; dat_bad = 0;
    for (int k = 0; k < exp_nout && k < out_dat.size(); k++) begin
      if (out_dat[k] !== val[k]) dat_bad++;
      if (out_c[k] - odrv[k] != 1) lat_bad++;
    end
    chk({tag, "_out_data_err"}, dat_bad, 0);
    chk({tag, "_out_latency_err"}, lat_bad, 0);
    chk({tag, "_done_owner"}, n_done[who], 1);
    chk({tag, "_done_other"}, n_done[oth], 0);
    chk({tag, "_err_owner"}, n_err[who], exp_err);
    chk({tag, "_err_other"}, n_err[oth], 0);
    chk({tag, "_gnt_in_done"}, int'(gnt_at_done), 0);
    $display("job %s owner=%0d gapped=%0d noise=%0d burst=%0d sdin=%0d outs=%0d done=%0d err=%0d",
             tag, who, gapped, noise, burst, sdin_q.size(), n_outv[who], n_done[who], n_err[who]);
  endtask

  typedef struct {
    int    who;
    bit    gapped;
    bit    noise;
    int    burst;
    int    exp_nout;
    int    exp_err;
    string tag;
  } job_t;

  job_t jobs[5];

  initial begin
    bit got;
    jobs[0] = '{0, 1'b0, 1'b0, 15, 15, 0, "single0"};
    jobs[1] = '{0, 1'b0, 1'b0,  1,  1, 0, "nosol0"};
    jobs[2] = '{1, 1'b1, 1'b1, 15, 15, 0, "gapnoise1"};
    jobs[3] = '{1, 1'b0, 1'b0,  0,  0, 1, "timeout1"};
    jobs[4] = '{0, 1'b1, 1'b1,  1,  1, 0, "gapnosol0"};

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    in_valid0 = 1'b0; in_valid1 = 1'b0; in0 = 4'd0; in1 = 4'd0;
    sd_out_valid = 1'b0; sd_out = 4'd0;
    clear_mon();
    #1;
    chk("reset_outputs", out_vec(), 0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_outputs", out_vec(), 0);

    // reset mid-feed after 40 nibbles
    req0 = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin tick(); got = gnt0; end
    chk("midrst_grant0", int'(got), 1);
    req0 = 1'b0;
    for (int j = 0; j < 40; j++) begin
      in_valid0 = 1'b1; in0 = 4'((j % 9) + 1);
      tick();
    end
    chk("midrst_gnt0_before", int'(gnt0), 1);
    chk("midrst_sdin_valid_before", int'(sd_in_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk("midrst_outputs_zero", out_vec(), 0);
    in_valid0 = 1'b0; in0 = 4'd0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    req1 = 1'b1;
    chk("midrst_gnt1_before_sample", int'(gnt1), 0);
    tick();
    chk("midrst_gnt1_after_sample", int'(gnt1), 1);
    chk("midrst_gnt0_after_sample", int'(gnt0), 0);
    req1 = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    $display("seq midreset done");

    for (int r = 0; r < 5; r++)
      do_job(jobs[r].who, jobs[r].gapped, jobs[r].noise, jobs[r].burst,
             jobs[r].exp_nout, jobs[r].exp_err, 1'b0, jobs[r].tag);

    // round robin with both requests held from reset
    rst_n = 1'b0;
    tick();
    gaps.delete(); order.delete();
    rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    do_job(0, 1'b0, 1'b0, 1, 1, 0, 1'b1, "rr_a");
    do_job(1, 1'b0, 1'b0, 1, 1, 0, 1'b1, "rr_b");
    do_job(0, 1'b0, 1'b0, 1, 1, 0, 1'b1, "rr_c");
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_order_len_ge3", int'(order.size() >= 3), 1);
    if (order.size() >= 3) begin
      chk("rr_order0", order[0], 0);
      chk("rr_order1", order[1], 1);
      chk("rr_order2", order[2], 0);
    end
    if (gaps.size() >= 3) begin
      chk("rr_gap1", gaps[1], 2);
      chk("rr_gap2", gaps[2], 2);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("grant_overlap_cycles", overlap, 0);
    chk("out_nonzero_when_invalid", zero_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1, "simulation time limit");
  end
endmodule
